// File: rtl/bypass_source_tracker_pkg.sv
// bypass_source_tracker_pkg: shared widths, stage indices and the youngest-match stall helper
package bypass_source_tracker_pkg;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 32;
    localparam int NSTG    = 3;
    localparam int ENTRY_W = 1 + REG_AW + DATA_W + 1;
    localparam int EX      = 0;
    localparam int MEM     = 1;
    localparam int WB      = 2;

    // Youngest valid writer of rs decides; an older ready copy behind a not-ready one still stalls
    function automatic logic src_stall(
        input logic [REG_AW-1:0]            rs,
        input logic [NSTG-1:0]              v,
        input logic [NSTG-1:0]              r,
        input logic [NSTG-1:0][REG_AW-1:0]  d
    );
        logic found;
        logic st;
        found = 1'b0;
        st    = 1'b0;
        for (int i = 0; i < NSTG; i++) begin
            if (!found && rs != '0 && v[i] && d[i] == rs) begin
                found = 1'b1;
                st    = ~r[i];
            end
        end
        return st;
    endfunction
endpackage

// File: rtl/bypass_source_tracker_if.sv
// bypass_source_tracker_if: pipeline-control, query and forwarding signals of the tracker
interface bypass_source_tracker_if;
    import bypass_source_tracker_pkg::*;
    logic              flush;
    logic              advance;
    logic              in_valid;
    logic [REG_AW-1:0] in_dest;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ld_resp_valid;
    logic [DATA_W-1:0] ld_resp_data;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] dest_ex;
    logic [REG_AW-1:0] dest_mem;
    logic [REG_AW-1:0] dest_wb;
    logic [DATA_W-1:0] data_ex;
    logic [DATA_W-1:0] data_mem;
    logic [DATA_W-1:0] data_wb;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, advance, in_valid, in_dest, in_data, in_ready,
               ld_resp_valid, ld_resp_data, rs1, rs2,
        input  dest_ex, dest_mem, dest_wb, data_ex, data_mem, data_wb, stall, stall_cnt
    );
    modport slave (
        input  flush, advance, in_valid, in_dest, in_data, in_ready,
               ld_resp_valid, ld_resp_data, rs1, rs2,
        output dest_ex, dest_mem, dest_wb, data_ex, data_mem, data_wb, stall, stall_cnt
    );
endinterface

// File: rtl/bypass_source_tracker_entry.sv
// bypass_entry: one in-flight writer slot {valid, dest, data, ready} with clear/load/merge controls
module bypass_entry
    import bypass_source_tracker_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_dest,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    input  logic              i_merge,
    input  logic [DATA_W-1:0] i_merge_data,
    output logic              o_valid,
    output logic [REG_AW-1:0] o_dest,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ready
);
    logic              r_valid;
    logic [REG_AW-1:0] r_dest;
    logic [DATA_W-1:0] r_data;
    logic              r_ready;

    // Clear beats load, load beats an in-place load-data merge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_dest  <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_dest  <= i_dest;
            r_data  <= i_data;
            r_ready <= i_ready;
        end else if (i_merge) begin
            r_data  <= i_merge_data;
            r_ready <= 1'b1;
        end
    end

    assign o_valid = r_valid;
    assign o_dest  = r_dest;
    assign o_data  = r_data;
    assign o_ready = r_ready;
endmodule

// File: rtl/bypass_source_tracker.sv
// bypass_source_tracker: EX/MEM/WB writer tracking, forwarding tags/data, load-use stall and stall counter
module bypass_source_tracker
    import bypass_source_tracker_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    bypass_source_tracker_if.slave  bus
);
    logic [NSTG-1:0]             w_valid;
    logic [NSTG-1:0]             w_ready;
    logic [NSTG-1:0][REG_AW-1:0] w_dest;
    logic [NSTG-1:0][DATA_W-1:0] w_data;
    logic [NSTG-1:0][REG_AW-1:0] w_fdest;
    logic [NSTG-1:0][DATA_W-1:0] w_fdata;
    logic                        w_mem_merge;
    logic [DATA_W-1:0]           w_mem_data;
    logic                        w_stall;
    logic [CNT_W-1:0]            r_stall_cnt;

    // A pending load in MEM picks up its data; on an advance edge the merged copy moves to WB
    assign w_mem_merge = w_valid[MEM] & ~w_ready[MEM] & bus.ld_resp_valid;
    assign w_mem_data  = w_mem_merge ? bus.ld_resp_data : w_data[MEM];

    bypass_entry u_ex (
        .clk(clk), .resetn(resetn), .i_clear(bus.flush), .i_load(bus.advance),
        .i_valid(bus.in_valid), .i_dest(bus.in_dest), .i_data(bus.in_data), .i_ready(bus.in_ready),
        .i_merge(1'b0), .i_merge_data('0),
        .o_valid(w_valid[EX]), .o_dest(w_dest[EX]), .o_data(w_data[EX]), .o_ready(w_ready[EX])
    );

    bypass_entry u_mem (
        .clk(clk), .resetn(resetn), .i_clear(bus.flush), .i_load(bus.advance),
        .i_valid(w_valid[EX]), .i_dest(w_dest[EX]), .i_data(w_data[EX]), .i_ready(w_ready[EX]),
        .i_merge(w_mem_merge), .i_merge_data(bus.ld_resp_data),
        .o_valid(w_valid[MEM]), .o_dest(w_dest[MEM]), .o_data(w_data[MEM]), .o_ready(w_ready[MEM])
    );

    bypass_entry u_wb (
        .clk(clk), .resetn(resetn), .i_clear(bus.flush), .i_load(bus.advance),
        .i_valid(w_valid[MEM]), .i_dest(w_dest[MEM]), .i_data(w_mem_data),
        .i_ready(w_ready[MEM] | w_mem_merge),
        .i_merge(1'b0), .i_merge_data('0),
        .o_valid(w_valid[WB]), .o_dest(w_dest[WB]), .o_data(w_data[WB]), .o_ready(w_ready[WB])
    );

    // Not-ready or invalid entries present tag 0 so the consumer mux never picks them
    always_comb begin
        for (int i = 0; i < NSTG; i++) begin
            w_fdest[i] = (w_valid[i] & w_ready[i]) ? w_dest[i] : '0;
            w_fdata[i] = (w_fdest[i] != '0) ? w_data[i] : '0;
        end
    end

    assign w_stall = src_stall(bus.rs1, w_valid, w_ready, w_dest) |
                     src_stall(bus.rs2, w_valid, w_ready, w_dest);

    // Saturating count of stalled cycles, untouched by flush
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign bus.dest_ex   = w_fdest[EX];
    assign bus.dest_mem  = w_fdest[MEM];
    assign bus.dest_wb   = w_fdest[WB];
    assign bus.data_ex   = w_fdata[EX];
    assign bus.data_mem  = w_fdata[MEM];
    assign bus.data_wb   = w_fdata[WB];
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_bypass_source_tracker.sv
// tb_bypass_source_tracker: directed + random stimulus against a pipeline-queue reference model
module tb_bypass_source_tracker;
    import bypass_source_tracker_pkg::*;

    localparam logic [31:0] PRESET = 32'hFFFF_FFFD;

    typedef struct {
        logic        v;
        logic [4:0]  d;
        logic [31:0] x;
        logic        r;
    } ment_t;
    typedef ment_t mpipe_t [3];

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic do_preset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    mpipe_t      m;
    logic [31:0] m_cnt;
    logic [31:0] cexp;

    always #5 clk = ~clk;

    bypass_source_tracker_if bif();

    bypass_source_tracker dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bif.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mpipe_t empty_pipe();
        mpipe_t p;
        foreach (p[i]) p[i] = '{1'b0, 5'd0, 32'd0, 1'b0};
        return p;
    endfunction

    // Youngest (lowest stage index) valid writer of rs, if any, decides
    function automatic logic m_stall_for(input mpipe_t p, input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        foreach (p[i]) if (p[i].v && p[i].d == rs) return !p[i].r;
        return 1'b0;
    endfunction

    function automatic logic m_stall(input mpipe_t p, input logic [4:0] a, input logic [4:0] b);
        return m_stall_for(p, a) || m_stall_for(p, b);
    endfunction

    function automatic mpipe_t next_pipe(input mpipe_t p);
        mpipe_t n;
        n = p;
        if (bif.flush) begin
            foreach (n[i]) n[i].v = 1'b0;
        end else begin
            if (n[1].v && !n[1].r && bif.ld_resp_valid) begin
                n[1].x = bif.ld_resp_data;
                n[1].r = 1'b1;
            end
            if (bif.advance) begin
                n[2] = n[1];
                n[1] = n[0];
                n[0] = '{bif.in_valid, bif.in_dest, bif.in_data, bif.in_ready};
            end
        end
        return n;
    endfunction

    function automatic logic [4:0] m_dest(input int i);
        return (m[i].v && m[i].r) ? m[i].d : 5'd0;
    endfunction

    function automatic logic [31:0] m_data(input int i);
        return (m_dest(i) != 0) ? m[i].x : 32'd0;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m     <= empty_pipe();
            m_cnt <= 32'd0;
        end else begin
            m_cnt <= do_preset ? PRESET :
                     (m_stall(m, bif.rs1, bif.rs2) && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
            m     <= next_pipe(m);
        end
    end

    always @(negedge clk) begin
        chk("dest_ex",   bif.dest_ex,   m_dest(0));
        chk("dest_mem",  bif.dest_mem,  m_dest(1));
        chk("dest_wb",   bif.dest_wb,   m_dest(2));
        chk("data_ex",   bif.data_ex,   m_data(0));
        chk("data_mem",  bif.data_mem,  m_data(1));
        chk("data_wb",   bif.data_wb,   m_data(2));
        chk("stall",     bif.stall,     m_stall(m, bif.rs1, bif.rs2));
        chk("stall_cnt", bif.stall_cnt, m_cnt);
    end

    task automatic set_in(input logic f, input logic a, input logic v, input logic [4:0] d,
                          input logic [31:0] x, input logic r, input logic lv, input logic [31:0] ld,
                          input logic [4:0] s1, input logic [4:0] s2);
        bif.flush = f; bif.advance = a; bif.in_valid = v; bif.in_dest = d; bif.in_data = x;
        bif.in_ready = r; bif.ld_resp_valid = lv; bif.ld_resp_data = ld; bif.rs1 = s1; bif.rs2 = s2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_dest_ex", bif.dest_ex, 0);
        chk("rst_cnt", bif.stall_cnt, 0);
        resetn = 1'b1;

        set_in(0, 1, 1, 5, 32'h11, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 5, 0);
        #1;
        chk("alu_dest_ex", bif.dest_ex, 5);
        chk("alu_data_ex", bif.data_ex, 32'h11);
        chk("alu_stall", bif.stall, 0);
        tick();
        chk("alu_dest_mem", bif.dest_mem, 5);
        chk("alu_data_mem", bif.data_mem, 32'h11);
        chk("alu_dest_ex0", bif.dest_ex, 0);
        tick();
        chk("alu_dest_wb", bif.dest_wb, 5);
        chk("alu_data_wb", bif.data_wb, 32'h11);
        tick();
        chk("alu_wb_gone", bif.dest_wb, 0);

        set_in(0, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 7);
        #1;
        chk("lu_stall_ex", bif.stall, 1);
        chk("lu_dest_ex", bif.dest_ex, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        #1;
        chk("lu_stall_mem", bif.stall, 1);
        chk("lu_dest_mem0", bif.dest_mem, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 32'hABCD, 0, 7);
        #1;
        chk("lu_stall_resp", bif.stall, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        #1;
        chk("lu_dest_mem", bif.dest_mem, 7);
        chk("lu_data_mem", bif.data_mem, 32'hABCD);
        chk("lu_stall_done", bif.stall, 0);
        chk("lu_cnt", bif.stall_cnt, 3);

        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        set_in(0, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 1, 32'h5A5A, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("adv_ld_dest_wb", bif.dest_wb, 7);
        chk("adv_ld_data_wb", bif.data_wb, 32'h5A5A);
        chk("adv_ld_dest_mem", bif.dest_mem, 0);

        set_in(0, 1, 1, 3, 32'h22, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        #1;
        chk("young_stall", bif.stall, 1);
        chk("young_dest_mem", bif.dest_mem, 3);
        chk("young_data_mem", bif.data_mem, 32'h22);
        tick();
        set_in(0, 1, 1, 0, 32'h99, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r0_stall", bif.stall, 0);
        chk("r0_dest_ex", bif.dest_ex, 0);

        set_in(1, 1, 1, 9, 32'h77, 1, 1, 32'h1, 0, 0);
        #1;
        cexp = m_cnt;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 9, 3);
        #1;
        chk("fl_dest_ex", bif.dest_ex, 0);
        chk("fl_dest_mem", bif.dest_mem, 0);
        chk("fl_dest_wb", bif.dest_wb, 0);
        chk("fl_stall", bif.stall, 0);
        chk("fl_cnt", bif.stall_cnt, cexp);

        set_in(0, 1, 1, 4, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        @(negedge clk);
        #1;
        force dut.r_stall_cnt = PRESET;
        do_preset = 1'b1;
        @(posedge clk);
        #1;
        release dut.r_stall_cnt;
        do_preset = 1'b0;
        chk("sat_preset", bif.stall_cnt, PRESET);
        tick();
        tick();
        tick();
        chk("sat_hold", bif.stall_cnt, 32'hFFFF_FFFF);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 15) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1),
                   ($urandom_range(0, 2) == 0), $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        set_in(0, 1, 1, 6, 32'h66, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_dest_ex", bif.dest_ex, 0);
        chk("ar_data_ex", bif.data_ex, 0);
        chk("ar_dest_mem", bif.dest_mem, 0);
        chk("ar_dest_wb", bif.dest_wb, 0);
        chk("ar_stall", bif.stall, 0);
        chk("ar_cnt", bif.stall_cnt, 0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
